gf2_poly_div_8bit: RTL and testbench
====================================

// Module: gf2_poly_div_8bit
// PURPOSE
//  Sequential carry-less (GF(2)[x]) polynomial divider, the inverse of the 8x8 -> 15-bit
//  carry-less multipliers. Takes a 15-bit dividend and an 8-bit divisor. Returns quotient and
//  remainder so that clmul(quo, divisor) ^ rem == dividend. Sits downstream of the
//  multiplier datapath for field reduction and multiplier self-check.
// PARAMETERS
//  W      8       divisor width (polynomial degree <= W-1)
//  DW     2*W-1   dividend / quotient width (15); derived, not overridable
// PORTS
//  clk        in   1    single clock; all state updates on rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    dividend/divisor valid
//  in_ready   out  1    divider idle, will accept
//  dividend   in   DW   dividend polynomial, bit i = coeff of x^i
//  divisor    in   W    divisor polynomial, bit i = coeff of x^i
//  out_valid  out  1    result valid, held until out_ready
//  out_ready  in   1    consumer accepts result
//  quotient   out  DW   quotient polynomial
//  remainder  out  W-1  remainder polynomial, degree < deg(divisor)
//  div_zero   out  1    divisor was 0; quotient = 0, remainder = 0
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0.
//  - FSM: IDLE -> RUN on in_valid&in_ready. RUN runs DW cycles, then -> DONE.
//    DONE -> IDLE on out_ready. Divisor==0 goes IDLE -> DONE directly with div_zero=1.
//  - in_ready = (state==IDLE) only. There is no accept in the same cycle as out handshake.
//    Next accept is possible the cycle after DONE -> IDLE.
//  - Accept: latch dividend into shift reg, divisor into d_r, deg_r = index of MSB set in divisor.
//    Clear partial p (W bits), cnt = DW-1.
//  - RUN iteration (one quotient bit per cycle, MSB first):
//    - t = {p, dividend_sr[DW-1]} (W+1 bits).
//    - qbit = t[deg_r]. If qbit, t ^= d_r. p = t[W-1:0].
//    - Shift qbit into quotient LSB. Shift dividend_sr left.
//  - After DW iterations: remainder = p[W-2:0]. Bits >= deg_r are guaranteed 0.
//    This is an assertion target.
//  - Latency: out_valid rises exactly DW+1 = 16 cycles after the accept edge.
//    Div-by-zero: 1 cycle.
//  - Outputs are stable while out_valid & !out_ready. in_valid is ignored outside IDLE.
//  - Divisor==1 (deg 0): quotient = dividend, remainder = 0.
//  - dividend degree < divisor degree: quotient = 0, remainder = dividend.
//  - rst asserted mid-RUN or in DONE: the result is dropped and all outputs return to reset
//    values on the next edge.
// STRUCTURE
//  - Shared package gf2_pkg: localparams W, DW; enum state_t {IDLE, RUN, DONE}.
//    Also a function clmul_ref() for benches.
//  - One sub-module: gf2_deg_enc (W-bit MSB priority encoder -> $clog2(W) degree, plus zero flag).
//  - The rest is one FSM + shift/XOR datapath in this file.
// TESTING
//  - dividend=15'h0100, divisor=8'h83 -> quotient=15'h0002, remainder=7'h06, div_zero=0.
//    out_valid 16 cycles after accept.
//  - dividend=15'h0005, divisor=8'h03 -> quotient=15'h0003, remainder=7'h00.
//    dividend=15'h0006 -> quotient=15'h0002.
//  - dividend=15'h0005, divisor=8'h08 -> quotient=0, remainder=7'h05.
//    divisor=8'h01 with dividend=15'h7FFF -> quotient=15'h7FFF, remainder=0.
//  - divisor=8'h00 -> div_zero=1, quotient=0, remainder=0, out_valid next cycle.
//    A following valid op is correct.
//  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
//    Reset pulse mid-RUN -> IDLE, out_valid never asserts for the dropped op.
//  - 2000 random (a,b) pairs with b!=0 and random out_ready stalls ->
//    clmul_ref(quotient,b)^remainder == a.
//    Also deg(remainder) < deg(b), and in_ready/out_valid are never both high.

Source files
------------

// File: rtl/gf2_pkg.sv
// Shared widths, FSM state encoding and a carry-less multiply reference
// for the GF(2)[x] divider and its benches.
package gf2_pkg;

  localparam int unsigned W    = 8;
  localparam int unsigned DW   = 2 * W - 1;
  localparam int unsigned DEGW = $clog2(W);
  localparam int unsigned CW   = $clog2(DW);
  localparam int unsigned PW   = DW + W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-width carry-less product of a DW-bit and a W-bit polynomial.
  function automatic logic [PW-1:0] clmul_ref(input logic [DW-1:0] a,
                                              input logic [W-1:0]  b);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (b[i]) acc = acc ^ (PW'(a) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf2_deg_enc.sv
// MSB priority encoder: degree of a W-bit polynomial plus an all-zero flag.
module gf2_deg_enc
  import gf2_pkg::*;
(
  input  logic [W-1:0]    value,
  output logic [DEGW-1:0] deg_c,
  output logic            zero_c
);

  always_comb begin
    deg_c  = '0;
    zero_c = (value == '0);
    for (int i = 0; i < int'(W); i++) begin
      if (value[i]) deg_c = DEGW'(i);
    end
  end

endmodule

// File: rtl/gf2_poly_div_8bit.sv
// Sequential GF(2)[x] long divider: one quotient bit per cycle, MSB first,
// with a valid/ready handshake on both sides.
module gf2_poly_div_8bit
  import gf2_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [W-1:0]  divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [W-2:0]  remainder,
  output logic          div_zero
);

  state_t          state;
  logic [DW-1:0]   div_sr;
  logic [DW-1:0]   quo_sr;
  logic [W-1:0]    d_r;
  logic [W-2:0]    p;
  logic [DEGW-1:0] deg_r;
  logic [CW-1:0]   cnt;
  logic            dz_r;

  logic [DEGW-1:0] deg_c;
  logic            zero_c;
  logic [W-1:0]    t_c;
  logic            qbit_c;
  logic [W-2:0]    p_next_c;

  gf2_deg_enc u_deg_enc (
    .value  (divisor),
    .deg_c  (deg_c),
    .zero_c (zero_c)
  );

  // Partial remainder always has degree < deg_r <= W-1, so its top bit is
  // never stored: t = {p, next dividend bit} fits exactly in W bits.
  always_comb begin
    t_c    = {p, div_sr[DW-1]};
    qbit_c = t_c[deg_r];
    if (qbit_c) t_c = t_c ^ d_r;
    p_next_c = t_c[W-2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      div_sr    <= '0;
      quo_sr    <= '0;
      d_r       <= '0;
      p         <= '0;
      deg_r     <= '0;
      cnt       <= '0;
      dz_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            div_sr   <= dividend;
            d_r      <= divisor;
            deg_r    <= deg_c;
            p        <= '0;
            quo_sr   <= '0;
            cnt      <= CW'(DW - 1);
            dz_r     <= zero_c;
            in_ready <= 1'b0;
            state    <= zero_c ? DONE : RUN;
          end
        end
        RUN: begin
          div_sr <= {div_sr[DW-2:0], 1'b0};
          quo_sr <= {quo_sr[DW-2:0], qbit_c};
          p      <= p_next_c;
          cnt    <= cnt - CW'(1);
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the result; handshake from the next.
          if (!out_valid) begin
            out_valid <= 1'b1;
            quotient  <= quo_sr;
            remainder <= p;
            div_zero  <= dz_r;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Final partial remainder must be strictly below the divisor degree.
  always_ff @(posedge clk) begin
    if (!rst && state == DONE && !out_valid && !dz_r) begin
      assert ((p >> deg_r) == '0);
    end
  end

endmodule

// File: tb/tb_gf2_poly_div_8bit.sv
// Directed table, handshake corner cases and randomized round-trip checks
// for the GF(2)[x] divider.
module tb_gf2_poly_div_8bit;
  import gf2_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [W-2:0]  remainder;
  logic          div_zero;

  int tests = 0;
  int fails = 0;

  gf2_poly_div_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [W-1:0]  b;
    logic [DW-1:0] q;
    logic [W-2:0]  r;
    logic          dz;
    int            lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake exclusivity watched on every cycle outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0 && in_ready === 1'b1 && out_valid === 1'b1) begin
      fails++;
      $display("FAIL ready_valid_overlap: in_ready=1 out_valid=1 at %0t, expected not both", $time);
    end
  end

  // Issue one operation; returns the first published result and its latency.
  task automatic run_op(input logic [DW-1:0] a, input logic [W-1:0] b, input int stall,
                        output logic [DW-1:0] q, output logic [W-2:0] r,
                        output logic dz, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("in_ready_timeout", 32'(n), 32'(0));
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    logic [DW-1:0] q, sq;
    logic [W-2:0]  r, sr;
    logic          dz;
    int            lat, degb, seen;
    logic [DW-1:0] ra;
    logic [W-1:0]  rb;

    vecs.push_back('{15'h0100, 8'h83, 15'h0002, 7'h06, 1'b0, 16});
    vecs.push_back('{15'h0005, 8'h03, 15'h0003, 7'h00, 1'b0, 16});
    vecs.push_back('{15'h0006, 8'h03, 15'h0002, 7'h00, 1'b0, 16});
    vecs.push_back('{15'h0005, 8'h08, 15'h0000, 7'h05, 1'b0, 16});
    vecs.push_back('{15'h1234, 8'h00, 15'h0000, 7'h00, 1'b1, 1});
    vecs.push_back('{15'h7FFF, 8'h01, 15'h7FFF, 7'h00, 1'b0, 16});
    vecs.push_back('{15'h0003, 8'h02, 15'h0001, 7'h01, 1'b0, 16});
    vecs.push_back('{15'h4000, 8'h80, 15'h0080, 7'h00, 1'b0, 16});
    vecs.push_back('{15'h000F, 8'h07, 15'h0002, 7'h01, 1'b0, 16});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_quotient", 32'(quotient), 32'(0));
    check("rst_remainder", 32'(remainder), 32'(0));
    check("rst_div_zero", 32'(div_zero), 32'(0));

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 0, q, r, dz, lat);
      check($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
      check($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d_div_zero", i), 32'(dz), 32'(vecs[i].dz));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Stall in DONE: outputs frozen, no new accept.
    @(negedge clk);
    dividend = 15'h0100; divisor = 8'h83; in_valid = 1'b1;
    @(posedge clk);
    #1;
    seen = 0;
    while (out_valid !== 1'b1 && seen < 100) begin
      @(posedge clk);
      #1 seen++;
    end
    dividend = 15'h0005; divisor = 8'h03;
    sq = quotient; sr = remainder;
    check("stall_quotient", 32'(sq), 32'h0002);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_out_valid", k), 32'(out_valid), 32'(1));
      check($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'(0));
      check($sformatf("stall%0d_quotient", k), 32'(quotient), 32'(sq));
      check($sformatf("stall%0d_remainder", k), 32'(remainder), 32'(sr));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("post_handshake_in_ready", 32'(in_ready), 32'(1));
    check("post_handshake_out_valid", 32'(out_valid), 32'(0));

    // Reset mid-RUN drops the operation.
    @(negedge clk);
    dividend = 15'h7FFF; divisor = 8'h01; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrun_rst_in_ready", 32'(in_ready), 32'(1));
    check("midrun_rst_out_valid", 32'(out_valid), 32'(0));
    check("midrun_rst_quotient", 32'(quotient), 32'(0));
    check("midrun_rst_remainder", 32'(remainder), 32'(0));
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (out_valid === 1'b1) seen++;
    end
    check("midrun_rst_no_result", 32'(seen), 32'(0));

    // Randomized round trip with output stalls.
    for (int k = 0; k < 2000; k++) begin
      ra = DW'($urandom);
      rb = W'($urandom_range(1, 255));
      degb = 0;
      for (int j = 0; j < int'(W); j++) if (rb[j]) degb = j;
      run_op(ra, rb, $urandom_range(0, 3), q, r, dz, lat);
      check($sformatf("rand%0d_roundtrip a=%0h b=%0h", k, ra, rb),
            32'(clmul_ref(q, rb) ^ PW'(r)), 32'(ra));
      check($sformatf("rand%0d_rem_degree", k), 32'(r >> degb), 32'(0));
      if (dz !== 1'b0 || lat != 16)
        check($sformatf("rand%0d_dz_latency", k), {dz, 31'(lat)}, 32'(16));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
